// File: rtl/mult_pkg.sv
// Shared types and constants for the shared Booth multiplier controller.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_NUM_REQ = 4;

   // Bits needed to hold 0..n-1; never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if (n > (1 << i)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first set req bit at or above pointer,
// wrapping around. Purely combinational.
module rr_arbiter
   import mult_pkg::*;
#(
   parameter int  NUM_REQ = DEF_NUM_REQ,
   localparam int PW      = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      pointer,
   output logic [NUM_REQ-1:0] grant
);

   int   idx;
   logic found;

   // Scan NUM_REQ positions starting at pointer; first hit wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = int'(pointer) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[idx[PW-1:0]]) begin
            grant[idx[PW-1:0]] = 1'b1;
            found              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_share_ctrl.sv
// One radix-2 Booth multiplier shared round-robin between NUM_REQ requesters.
// Optional build macro MULT_SHARE_ZERO_SKIP_EN: a zero operand at grant skips
// the Booth iterations and reports product 0 straight away.
//
// state | meaning
// IDLE  | waiting for a request; grants and latches operands
// RUN   | WIDTH Booth add/sub + arithmetic shift iterations
// DONE  | one cycle: publish product, pulse done, advance pointer
module mult_share_ctrl
   import mult_pkg::*;
#(
   parameter int  NUM_REQ = DEF_NUM_REQ,
   parameter int  WIDTH   = DEF_WIDTH,
   localparam int PW      = clog2(NUM_REQ),
   localparam int CW      = clog2(WIDTH)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] multiplicand,
   input  logic [NUM_REQ*WIDTH-1:0] multiplier,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     busy,
   output logic                     done,
   output logic [2*WIDTH-1:0]       product
);

   state_t             state;
   logic [PW-1:0]      ptr;
   logic [PW-1:0]      gidx;
   logic [CW-1:0]      cnt;
   logic [WIDTH:0]     a_reg;
   logic [WIDTH:0]     m_reg;
   logic [WIDTH-1:0]   q_reg;
   logic               q_1;

   logic [NUM_REQ-1:0] arb_grant;
   logic [PW-1:0]      sel_idx;
   logic [WIDTH-1:0]   sel_mcand;
   logic [WIDTH-1:0]   sel_mplier;
   logic [WIDTH:0]     booth_sum;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req     (req),
      .pointer (ptr),
      .grant   (arb_grant)
   );

   // Encode the arbiter's one-hot choice and pick that requester's operands.
   always_comb begin
      sel_idx    = '0;
      sel_mcand  = '0;
      sel_mplier = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_idx    = PW'(i);
            sel_mcand  = multiplicand[i*WIDTH +: WIDTH];
            sel_mplier = multiplier[i*WIDTH +: WIDTH];
         end
      end
   end

   // Booth recoding of {Q[0], q_1}: 01 adds M, 10 subtracts M.
   always_comb begin
      case ({q_reg[0], q_1})
         2'b01:   booth_sum = a_reg + m_reg;
         2'b10:   booth_sum = a_reg - m_reg;
         default: booth_sum = a_reg;
      endcase
   end

   // Control FSM plus Booth datapath registers; all outputs registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         gidx    <= '0;
         cnt     <= '0;
         a_reg   <= '0;
         m_reg   <= '0;
         q_reg   <= '0;
         q_1     <= 1'b0;
         grant   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (|arb_grant) begin
                  grant <= arb_grant;
                  gidx  <= sel_idx;
                  busy  <= 1'b1;
                  a_reg <= '0;
                  q_reg <= sel_mplier;
                  q_1   <= 1'b0;
                  m_reg <= {sel_mcand[WIDTH-1], sel_mcand};
                  cnt   <= '0;
`ifdef MULT_SHARE_ZERO_SKIP_EN
                  // Clearing Q makes {A,Q} read as zero in DONE.
                  if (sel_mcand == '0 || sel_mplier == '0) begin
                     q_reg <= '0;
                     state <= DONE;
                  end else begin
                     state <= RUN;
                  end
`else
                  state <= RUN;
`endif
               end else begin
                  busy <= 1'b0;
               end
            end
            RUN: begin
               a_reg <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
               q_reg <= {booth_sum[0], q_reg[WIDTH-1:1]};
               q_1   <= q_reg[0];
               if (cnt == CW'(WIDTH-1)) begin
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               product <= {a_reg[WIDTH-1:0], q_reg};
               done    <= 1'b1;
               busy    <= 1'b1;
               ptr     <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl: stimulus pushes expected
// {grant, product}; the monitor pops and compares on every done pulse.
module tb_mult_share_ctrl;

   localparam int NR = 4;
   localparam int W  = 4;
`ifdef MULT_SHARE_ZERO_SKIP_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = W + 1;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic [NR-1:0]     req;
   logic [NR*W-1:0]   multiplicand;
   logic [NR*W-1:0]   multiplier;
   logic [NR-1:0]     grant;
   logic              busy;
   logic              done;
   logic [2*W-1:0]    product;

   typedef struct packed {
      logic [NR-1:0]  g;
      logic [2*W-1:0] p;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   mult_share_ctrl #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clock        (clock),
      .reset        (reset),
      .req          (req),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .grant        (grant),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("done_grant", 32'(grant), 32'(mon_e.g));
            check("done_product", 32'(product), 32'(mon_e.p));
         end
      end
   end

   task automatic push_exp(input int owner, input logic [2*W-1:0] p);
      exp_t e;
      e.g        = '0;
      e.g[owner] = 1'b1;
      e.p        = p;
      sb.push_back(e);
   endtask

   // mode 0: plain; 1: change owner's operands mid-RUN; 2: drop req mid-RUN.
   task automatic run_op(input string name, input logic [NR-1:0] mask, input int owner,
                         input logic [W-1:0] mc, input logic [W-1:0] mp,
                         input logic [2*W-1:0] exp_p, input int lat, input int mode);
      int   start;
      int   n;
      bit   seen;
      logic [NR-1:0] g1;
      g1        = '0;
      g1[owner] = 1'b1;
      @(posedge clock);
      #1;
      multiplicand[owner*W +: W] = mc;
      multiplier[owner*W +: W]   = mp;
      req   = mask;
      start = cyc + 1;
      push_exp(owner, exp_p);
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 40) begin
         @(negedge clock);
         n++;
         if (cyc == start) begin
            check({name, "_busy_after_grant"}, 32'(busy), 32'd1);
            check({name, "_grant_after_grant"}, 32'(grant), 32'(g1));
         end
         if (cyc == start + 2 && mode == 1) begin
            multiplicand[owner*W +: W] = 4'h7;
            multiplier[owner*W +: W]   = 4'h7;
         end
         if (cyc == start + 2 && mode == 2) req = '0;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         check({name, "_timeout"}, 32'd0, 32'd1);
         req = '0;
      end else begin
         check({name, "_latency"}, 32'(cyc - start), 32'(lat));
         check({name, "_busy_at_done"}, 32'(busy), 32'd1);
         req = '0;
         @(negedge clock);
         check({name, "_busy_after"}, 32'(busy), 32'd0);
         check({name, "_done_pulse"}, 32'(done), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      int start;
      int nd;
      int last;
      bit stop;

      reset        = 1'b1;
      req          = '0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (2) @(negedge clock);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      reset = 1'b0;

      run_op("m3x5",  4'b0001, 0, 4'hD, 4'h5, 8'hF1, W + 1, 0);
      run_op("m8x8",  4'b0001, 0, 4'h8, 4'h8, 8'h40, W + 1, 0);
      run_op("p7xm8", 4'b0001, 0, 4'h7, 4'h8, 8'hC8, W + 1, 0);
      run_op("m1xm1", 4'b0001, 0, 4'hF, 4'hF, 8'h01, W + 1, 0);

      // Return the pointer to 0, then hold every request.
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      multiplicand = {4'hC, 4'h5, 4'hE, 4'h2};
      multiplier   = {4'hC, 4'h9, 4'h3, 4'h3};
      push_exp(0, 8'h06);
      push_exp(1, 8'hFA);
      push_exp(2, 8'hDD);
      push_exp(3, 8'h10);
      push_exp(0, 8'h06);
      @(posedge clock);
      #1;
      req   = 4'hF;
      start = cyc + 1;
      nd    = 0;
      last  = 0;
      stop  = 1'b0;
      for (int n = 0; n < 100 && !stop; n++) begin
         @(negedge clock);
         if (done) begin
            nd++;
            if (nd == 1) check("rr_first_latency", 32'(cyc - start), 32'(W + 1));
            else check("rr_throughput", 32'(cyc - last), 32'(W + 2));
            last = cyc;
            if (nd == 5) begin
               req  = '0;
               stop = 1'b1;
            end
         end
      end
      if (!stop) begin
         check("rr_timeout", 32'(nd), 32'd5);
         req = '0;
      end
      @(negedge clock);
      check("rr_busy_after", 32'(busy), 32'd0);

      run_op("chg_ops", 4'b0010, 1, 4'h3, 4'h3, 8'h09, W + 1, 1);
      run_op("drop_req", 4'b0100, 2, 4'hB, 4'h6, 8'hE2, W + 1, 2);

      // Abort in the third RUN cycle: no done, everything back to reset values.
      @(posedge clock);
      #1;
      multiplicand[3*W +: W] = 4'h1;
      multiplier[3*W +: W]   = 4'h1;
      req   = 4'b1000;
      start = cyc + 1;
      for (int n = 0; n < 20 && cyc != start + 2; n++) @(negedge clock);
      check("abort_busy_in_run", 32'(busy), 32'd1);
      reset = 1'b1;
      req   = '0;
      @(negedge clock);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_grant", 32'(grant), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_product", 32'(product), 32'd0);
      reset = 1'b0;
      repeat (8) @(negedge clock);

      run_op("recover_ptr0", 4'b1001, 0, 4'h3, 4'h2, 8'h06, W + 1, 0);
      run_op("zero_op", 4'b0001, 0, 4'h0, 4'hB, 8'h00, ZLAT, 0);

      repeat (4) @(negedge clock);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Shares one sequential radix-2 Booth signed multiplier between NUM_REQ requesters using round-robin arbitration.
- Each requester presents a signed multiplicand/multiplier pair. The block grants one requester, runs WIDTH Booth iterations, and returns a 2*WIDTH-bit signed product with a one-cycle done pulse tagged by grant.
- Replaces per-requester combinational multipliers in the arithmetic datapath.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 4: operand width in bits, two's complement.

Ports:
- clock, input, 1: single clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- req, input, NUM_REQ: request per requester; level, held until that requester sees done with its grant bit.
- multiplicand, input, NUM_REQ*WIDTH: slice i belongs to requester i; signed.
- multiplier, input, NUM_REQ*WIDTH: slice i belongs to requester i; signed.
- grant, output, NUM_REQ: one-hot owner of the current or last operation.
- busy, output, 1: high while an operation is in flight.
- done, output, 1: one-cycle pulse; product valid for the grant owner.
- product, output, 2*WIDTH: signed product; holds until the next done.

Behaviour:
- Reset values: grant=0, busy=0, done=0, product=0, FSM=IDLE, round-robin pointer=0, iteration counter=0, datapath registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req!=0, pick the first set req bit searching from the pointer upward with wrap.
  - Register grant one-hot, latch that requester's operands, go to RUN.
  - busy=1 from the next cycle.
  - If req==0, stay in IDLE with busy=0.
- RUN (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Registers: A is WIDTH+1 bits, starts at 0. Q=multiplier. q_1 starts at 0. M=multiplicand sign-extended to WIDTH+1 bits.
  - Each cycle, based on {Q[0],q_1}: 01 → A=A+M; 10 → A=A−M; 00/11 → no add.
  - Then arithmetic-shift {A,Q,q_1} right by one.
  - A is WIDTH+1 bits so that −2^(WIDTH-1) × −2^(WIDTH-1) is exact.
  - After the last iteration, go to DONE.
- DONE:
  - Lasts one cycle: product={A[WIDTH-1:0],Q}, done=1, busy=1, grant unchanged.
  - Pointer = granted index+1 (mod NUM_REQ).
  - Next state is IDLE.
- Latency: request sampled at edge N → done high in cycle N+WIDTH+2 (6 cycles for WIDTH=4). Back-to-back grant is possible from IDLE the cycle after DONE.
- Throughput: one product per WIDTH+2 cycles.
- Operands are sampled only at grant. Changes to the inputs during RUN are ignored.
- A req deasserted mid-operation does not abort: the operation completes, done pulses, and the result is discarded by the owner.
- New req bits during RUN/DONE wait for IDLE. No request is lost while it is held.
- grant stays valid after DONE until the next grant. done is the only qualifier for product.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,2,…,NUM_REQ-1,0. Any held request is served within NUM_REQ operations.
- Reset asserted in any state aborts the operation. All outputs return to reset values on that edge, with no done pulse.

Optional Feature:
- Macro: MULT_SHARE_ZERO_SKIP_EN.
- Defined: in IDLE, if the granted multiplicand or multiplier is 0, go directly to DONE with product=0. Latency drops to 2 cycles (done in N+2); pointer update is unchanged.
- Undefined: every operation takes the full WIDTH iterations, even for zero operands.

Decomposition:
- Package mult_pkg holds:
  - state typedef: IDLE/RUN/DONE;
  - default WIDTH and NUM_REQ constants;
  - the counter width function clog2(WIDTH).
- Sub-module rr_arbiter:
  - parameter NUM_REQ;
  - inputs req and pointer; output one-hot grant;
  - purely combinational;
  - reused elsewhere.
- The Booth step stays inline in mult_share_ctrl.

Test Plan:
- Reset, then req=0001 with req0 operands −3 × 5 → grant=0001, busy=1 cycles N+1..N+6, done in N+6 (WIDTH=4), product=8'hF1.
- req0 operands −8 × −8 → product=8'h40. Then req0 operands 7 × −8 → product=8'hC8. Then −1 × −1 → product=8'h01.
- req=1111 held continuously, distinct operands per requester → grant sequence 0001,0010,0100,1000,0001; each product matches its requester's operands.
- Change the granted requester's operands during RUN → product reflects operands at grant. Drop req mid-RUN → done still pulses once.
- Assert reset in the third RUN cycle → next edge busy=0, done never pulses, grant=0. The next request is granted from requester 0.
- With MULT_SHARE_ZERO_SKIP_EN defined, request 0 × −5 → done at N+2, product=0. Undefined → done at N+6, product=0.
